dmem_mailbox: RTL and testbench

// - Memory-mapped responder on the core data-memory bus (addr / wdata / we / rdata).
// - Sits beside data_mem; the top level muxes rdata using o_sel.
// - Core writes push words into a TX FIFO, drained by an external valid/ready consumer.
// - An external valid/ready producer fills an RX FIFO, which the core reads and pops.

---
 rtl/dmem_mailbox.sv | 238 +++++++++++++++++++++++
 tb/tb_dmem_mailbox.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_mailbox.sv
// -----------------------------------------------------------------------------
// dmem_mailbox
//
// Memory-mapped mailbox that sits beside data_mem on the core data-memory bus.
// Core stores to TXDATA push words into a TX FIFO that an external valid/ready
// consumer drains. An external valid/ready producer fills an RX FIFO that the
// core reads non-destructively at RXDATA and pops by writing RXDATA.
//
// Register map (offset = i_addr[3:2], i_addr[1:0] ignored):
//   0x0 TXDATA  W: push i_wdata              R: 0
//   0x4 STATUS  R: [0] tx_full [1] tx_empty [2] rx_full [3] rx_empty
//                  [4] tx_ovf  [5] rx_unf  [15:8] tx_count [23:16] rx_count
//   0x8 RXDATA  R: RX head (0 if empty)      W: pop (any value)
//   0xC CTRL    W: [0] flush TX [1] flush RX [2] irq_en [3] clear sticky
//               R: {29'b0, irq_en, 2'b0}
//
// Ports:
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_addr, i_wdata, i_we   core bus request (i_we is a 1-cycle store pulse)
//   o_sel                   combinational: address falls in this window
//   o_rdata                 combinational read data, 0 when not selected
//   o_tx_valid, o_tx_data,
//   i_tx_ready              TX stream towards the external consumer
//   i_rx_valid, i_rx_data,
//   o_rx_ready              RX stream from the external producer
//   o_irq                   interrupt request
//
// Optional feature macro: DMEM_MAILBOX_IRQ_EN
//   defined   : irq_en is stored; o_irq is registered from
//               irq_en & (!rx_empty | tx_ovf | rx_unf), one cycle behind.
//   undefined : o_irq tied 0; CTRL[2] is not stored and reads 0.
// -----------------------------------------------------------------------------
module dmem_mailbox #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
  parameter int          DEPTH     = 8,
  parameter int          DW        = 32
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic [31:0]   i_addr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_we,
  output logic          o_sel,
  output logic [DW-1:0] o_rdata,
  output logic          o_tx_valid,
  output logic [DW-1:0] o_tx_data,
  input  logic          i_tx_ready,
  input  logic          i_rx_valid,
  input  logic [DW-1:0] i_rx_data,
  output logic          o_rx_ready,
  output logic          o_irq
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [1:0] OFF_TXDATA = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_RXDATA = 2'd2;
  localparam logic [1:0] OFF_CTRL   = 2'd3;

  // Bus decode
  logic [1:0] off;
  logic       wr_en;
  logic       ctrl_wr;
  logic       unused_addr;

  assign o_sel       = (i_addr[31:4] == BASE_ADDR[31:4]);
  assign off         = i_addr[3:2];
  assign wr_en       = i_we & o_sel;
  assign ctrl_wr     = wr_en & (off == OFF_CTRL);
  assign unused_addr = ^i_addr[1:0];

  logic tx_flush;
  logic rx_flush;
  logic sticky_clr;

  assign tx_flush   = ctrl_wr & i_wdata[0];
  assign rx_flush   = ctrl_wr & i_wdata[1];
  assign sticky_clr = ctrl_wr & i_wdata[3];

  // TX FIFO state
  logic [DW-1:0] tx_mem [DEPTH];
  logic [PW-1:0] tx_wr_ptr;
  logic [PW-1:0] tx_rd_ptr;
  logic [CW-1:0] tx_count;
  logic          tx_full;
  logic          tx_empty;
  logic          tx_push_req;
  logic          tx_push;
  logic          tx_pop;
  logic          tx_ovf;
  logic          tx_ovf_set;

  // RX FIFO state
  logic [DW-1:0] rx_mem [DEPTH];
  logic [PW-1:0] rx_wr_ptr;
  logic [PW-1:0] rx_rd_ptr;
  logic [CW-1:0] rx_count;
  logic          rx_full;
  logic          rx_empty;
  logic          rx_push;
  logic          rx_pop_req;
  logic          rx_pop;
  logic          rx_unf;
  logic          rx_unf_set;

  // Full/empty come from the start-of-cycle count, so a pop in the same
  // cycle never makes room for a push that arrives while full.
  assign tx_full  = (tx_count == CW'(DEPTH));
  assign tx_empty = (tx_count == '0);
  assign rx_full  = (rx_count == CW'(DEPTH));
  assign rx_empty = (rx_count == '0);

  assign tx_push_req = wr_en & (off == OFF_TXDATA);
  assign tx_push     = tx_push_req & ~tx_full;
  assign tx_ovf_set  = tx_push_req & tx_full;

  // Outputs are forced quiet while reset is held so that no handshake can
  // complete against stale pre-reset state.
  assign o_tx_valid = ~tx_empty & ~i_reset;
  assign o_tx_data  = (tx_empty | i_reset) ? '0 : tx_mem[tx_rd_ptr];
  assign tx_pop     = o_tx_valid & i_tx_ready;

  assign o_rx_ready = ~rx_full & ~i_reset;
  assign rx_push    = i_rx_valid & o_rx_ready;
  assign rx_pop_req = wr_en & (off == OFF_RXDATA);
  assign rx_pop     = rx_pop_req & ~rx_empty;
  assign rx_unf_set = rx_pop_req & rx_empty;

  // TX pointers and count; flush overrides any same-cycle push/pop
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
    end else if (tx_flush) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + PW'(1);
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + PW'(1);
      unique case ({tx_push, tx_pop})
        2'b10:   tx_count <= tx_count + CW'(1);
        2'b01:   tx_count <= tx_count - CW'(1);
        default: tx_count <= tx_count;
      endcase
    end
  end

  // TX storage (data only, not reset; a write into a flushed slot is harmless
  // because the pointers restart from zero)
  always_ff @(posedge i_clk) begin
    if (tx_push) tx_mem[tx_wr_ptr] <= i_wdata;
  end

  // RX pointers and count; flush overrides any same-cycle push/pop
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
    end else if (rx_flush) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
    end else begin
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + PW'(1);
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + PW'(1);
      unique case ({rx_push, rx_pop})
        2'b10:   rx_count <= rx_count + CW'(1);
        2'b01:   rx_count <= rx_count - CW'(1);
        default: rx_count <= rx_count;
      endcase
    end
  end

  // RX storage
  always_ff @(posedge i_clk) begin
    if (rx_push) rx_mem[rx_wr_ptr] <= i_rx_data;
  end

  // Sticky error flags; a new event in the same cycle as a clear wins
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      tx_ovf <= 1'b0;
      rx_unf <= 1'b0;
    end else begin
      tx_ovf <= (tx_ovf & ~sticky_clr) | tx_ovf_set;
      rx_unf <= (rx_unf & ~sticky_clr) | rx_unf_set;
    end
  end

  // Interrupt
  logic irq_en_rd;

`ifdef DMEM_MAILBOX_IRQ_EN
  logic irq_en;
  logic irq_p1;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      irq_en <= 1'b0;
      irq_p1 <= 1'b0;
    end else begin
      if (ctrl_wr) irq_en <= i_wdata[2];
      irq_p1 <= irq_en & (~rx_empty | tx_ovf | rx_unf);
    end
  end

  assign irq_en_rd = irq_en;
  assign o_irq     = irq_p1 & ~i_reset;
`else
  assign irq_en_rd = 1'b0;
  assign o_irq     = 1'b0;
`endif

  // Read mux
  logic [31:0] status;

  assign status = {8'h00, 8'(rx_count), 8'(tx_count),
                   2'b00, rx_unf, tx_ovf, rx_empty, rx_full, tx_empty, tx_full};

  always_comb begin
    o_rdata = '0;
    if (o_sel) begin
      unique case (off)
        OFF_TXDATA: o_rdata = '0;
        OFF_STATUS: o_rdata = DW'(status);
        OFF_RXDATA: o_rdata = rx_empty ? '0 : rx_mem[rx_rd_ptr];
        OFF_CTRL:   o_rdata = DW'({irq_en_rd, 2'b00});
        default:    o_rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_mailbox.sv
module tb_dmem_mailbox;

  localparam int          DEPTH = 8;
  localparam int          DW    = 32;
  localparam logic [31:0] BASE  = 32'h0000_1000;
`ifdef DMEM_MAILBOX_IRQ_EN
  localparam bit IRQ = 1'b1;
`else
  localparam bit IRQ = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   addr;
  logic [DW-1:0] wdata;
  logic          we;
  logic          sel;
  logic [DW-1:0] rdata;
  logic          tx_valid;
  logic [DW-1:0] tx_data;
  logic          tx_ready;
  logic          rx_valid;
  logic [DW-1:0] rx_data;
  logic          rx_ready;
  logic          irq;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dmem_mailbox #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .DW(DW)) dut (
    .i_clk      (clk),
    .i_reset    (rst),
    .i_addr     (addr),
    .i_wdata    (wdata),
    .i_we       (we),
    .o_sel      (sel),
    .o_rdata    (rdata),
    .o_tx_valid (tx_valid),
    .o_tx_data  (tx_data),
    .i_tx_ready (tx_ready),
    .i_rx_valid (rx_valid),
    .i_rx_data  (rx_data),
    .o_rx_ready (rx_ready),
    .o_irq      (irq)
  );

  // Reference model: two queues plus flag bits
  logic [DW-1:0] txq[$];
  logic [DW-1:0] rxq[$];
  bit m_tx_ovf, m_rx_unf, m_irq_en, m_irq;

  function automatic bit exp_sel(input logic [31:0] a);
    return a[31:4] == BASE[31:4];
  endfunction

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    s = '0;
    s[0] = (txq.size() == DEPTH);
    s[1] = (txq.size() == 0);
    s[2] = (rxq.size() == DEPTH);
    s[3] = (rxq.size() == 0);
    s[4] = m_tx_ovf;
    s[5] = m_rx_unf;
    s[15:8]  = 8'(txq.size());
    s[23:16] = 8'(rxq.size());
    return s;
  endfunction

  function automatic logic [DW-1:0] m_rdata(input logic [31:0] a);
    if (!exp_sel(a)) return '0;
    case (a[3:2])
      2'd1:    return m_status();
      2'd2:    return (rxq.size() != 0) ? rxq[0] : '0;
      2'd3:    return {29'b0, m_irq_en, 2'b00};
      default: return '0;
    endcase
  endfunction

  function automatic bit exp_tx_valid();
    return !rst && txq.size() != 0;
  endfunction

  function automatic logic [DW-1:0] exp_tx_data();
    return (!rst && txq.size() != 0) ? txq[0] : '0;
  endfunction

  function automatic bit exp_rx_ready();
    return !rst && rxq.size() < DEPTH;
  endfunction

  function automatic bit exp_irq();
    return !rst && m_irq;
  endfunction

  // Advance the model by one clock edge using the inputs currently applied
  task automatic model_edge();
    int tn, rn;
    bit wr, irq_nx, ovf_set, unf_set;
    logic [1:0] o;
    if (rst) begin
      txq.delete(); rxq.delete();
      m_tx_ovf = 0; m_rx_unf = 0; m_irq_en = 0; m_irq = 0;
      return;
    end
    tn = txq.size();
    rn = rxq.size();
    o  = addr[3:2];
    wr = we && exp_sel(addr);
    irq_nx  = m_irq_en && (rn != 0 || m_tx_ovf || m_rx_unf);
    ovf_set = 0;
    unf_set = 0;
    if (tn != 0 && tx_ready) void'(txq.pop_front());
    if (wr && o == 2'd0) begin
      if (tn == DEPTH) ovf_set = 1; else txq.push_back(wdata);
    end
    if (wr && o == 2'd2) begin
      if (rn == 0) unf_set = 1; else void'(rxq.pop_front());
    end
    if (rx_valid && rn < DEPTH) rxq.push_back(rx_data);
    if (wr && o == 2'd3) begin
      if (wdata[0]) txq.delete();
      if (wdata[1]) rxq.delete();
      if (IRQ) m_irq_en = wdata[2];
      if (wdata[3]) begin m_tx_ovf = 0; m_rx_unf = 0; end
    end
    m_tx_ovf = m_tx_ovf | ovf_set;
    m_rx_unf = m_rx_unf | unf_set;
    m_irq    = IRQ ? irq_nx : 1'b0;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 0; addr = '0; wdata = '0; tx_ready = 0; rx_valid = 0; rx_data = '0;
  endtask

  task automatic test_reset();
    rst = 1; idle();
    #1;
    checks++;
    if (tx_valid !== 1'b0 || tx_data !== '0 || rx_ready !== 1'b0 || irq !== 1'b0) begin
      failures++;
      $display("FAIL reset_during got valid=%b data=%h ready=%b irq=%b exp 0/0/0/0",
               tx_valid, tx_data, rx_ready, irq);
    end
    step(); step();
    rst = 0; addr = BASE + 32'h4;
    #1;
    checks++;
    if (rdata !== 32'h0000_000A) begin
      failures++; $display("FAIL reset_status got=%h exp=%h", rdata, 32'h0000_000A);
    end
    checks++;
    if (tx_valid !== 1'b0 || rx_ready !== 1'b1 || sel !== 1'b1) begin
      failures++;
      $display("FAIL reset_after got valid=%b ready=%b sel=%b exp 0/1/1", tx_valid, rx_ready, sel);
    end
    addr = 32'h0000_2004;
    #1;
    checks++;
    if (sel !== 1'b0 || rdata !== '0) begin
      failures++; $display("FAIL outside_window got sel=%b rdata=%h exp 0/0", sel, rdata);
    end
  endtask

  task automatic test_tx_order();
    logic [DW-1:0] w[3];
    w[0] = 32'h11; w[1] = 32'h22; w[2] = 32'h33;
    for (int i = 0; i < 3; i++) begin
      we = 1; addr = BASE; wdata = w[i];
      step();
    end
    we = 0; addr = BASE + 32'h4;
    #1;
    checks++;
    if (rdata[15:8] !== 8'd3 || tx_data !== 32'h11 || tx_valid !== 1'b1) begin
      failures++;
      $display("FAIL tx_fill got count=%0d head=%h valid=%b exp 3/00000011/1",
               rdata[15:8], tx_data, tx_valid);
    end
    tx_ready = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (tx_valid !== 1'b1 || tx_data !== w[i]) begin
        failures++;
        $display("FAIL tx_drain[%0d] got valid=%b data=%h exp 1/%h", i, tx_valid, tx_data, w[i]);
      end
      step();
    end
    checks++;
    if (tx_valid !== 1'b0) begin
      failures++; $display("FAIL tx_drained got valid=%b exp 0", tx_valid);
    end
    tx_ready = 0;
  endtask

  task automatic test_tx_overflow();
    for (int i = 0; i < DEPTH + 1; i++) begin
      we = 1; addr = BASE; wdata = $urandom;
      step();
    end
    we = 0; addr = BASE + 32'h4;
    #1;
    checks++;
    if (rdata !== 32'h0000_0819 || rdata !== m_rdata(addr)) begin
      failures++; $display("FAIL tx_overflow got=%h exp=%h", rdata, 32'h0000_0819);
    end
    checks++;
    if (tx_data !== exp_tx_data()) begin
      failures++; $display("FAIL tx_ovf_head got=%h exp=%h", tx_data, exp_tx_data());
    end
    we = 1; addr = BASE + 32'hC; wdata = 32'h8;
    step();
    we = 0; addr = BASE + 32'h4;
    #1;
    checks++;
    if (rdata !== 32'h0000_0809) begin
      failures++; $display("FAIL sticky_clear got=%h exp=%h", rdata, 32'h0000_0809);
    end
    we = 1; addr = BASE + 32'hC; wdata = 32'h1;
    step();
    we = 0; addr = BASE + 32'h4;
    #1;
    checks++;
    if (rdata !== 32'h0000_000A || tx_valid !== 1'b0) begin
      failures++; $display("FAIL tx_flush got=%h valid=%b exp=0000000a/0", rdata, tx_valid);
    end
  endtask

  task automatic test_rx();
    we = 1; addr = BASE + 32'hC; wdata = 32'h4;
    step();
    we = 0; addr = BASE + 32'hC;
    #1;
    checks++;
    if (rdata !== (IRQ ? 32'h4 : 32'h0)) begin
      failures++; $display("FAIL ctrl_read got=%h exp=%h", rdata, (IRQ ? 32'h4 : 32'h0));
    end
    rx_valid = 1; rx_data = 32'hA5;
    step();
    rx_valid = 0; addr = BASE + 32'h8;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (rdata !== 32'hA5) begin
        failures++; $display("FAIL rx_peek[%0d] got=%h exp=%h", i, rdata, 32'hA5);
      end
      step();
    end
    checks++;
    if (irq !== IRQ) begin
      failures++; $display("FAIL irq_rx got=%b exp=%b", irq, IRQ);
    end
    we = 1; wdata = $urandom;
    step();
    we = 0; addr = BASE + 32'h4;
    #1;
    checks++;
    if (rdata[3] !== 1'b1 || rdata[5] !== 1'b0) begin
      failures++; $display("FAIL rx_pop got status=%h exp rx_empty=1 rx_unf=0", rdata);
    end
    we = 1; addr = BASE + 32'h8; wdata = $urandom;
    step();
    we = 0; addr = BASE + 32'h4;
    #1;
    checks++;
    if (rdata[5] !== 1'b1 || irq !== 1'b0) begin
      failures++; $display("FAIL rx_unf got status=%h irq=%b exp bit5=1 irq=0", rdata, irq);
    end
    step();
    checks++;
    if (irq !== IRQ || irq !== exp_irq()) begin
      failures++; $display("FAIL irq_unf got=%b exp=%b", irq, IRQ);
    end
    we = 1; addr = BASE + 32'hC; wdata = 32'h8;
    step();
    we = 0;
  endtask

  task automatic test_rx_full();
    for (int i = 0; i < DEPTH; i++) begin
      rx_valid = 1; rx_data = $urandom;
      #1;
      checks++;
      if (rx_ready !== 1'b1) begin
        failures++; $display("FAIL rx_fill_ready[%0d] got=%b exp=1", i, rx_ready);
      end
      step();
    end
    rx_data = 32'hBEEF_0001;
    #1;
    checks++;
    if (rx_ready !== 1'b0) begin
      failures++; $display("FAIL rx_full_ready got=%b exp=0", rx_ready);
    end
    we = 1; addr = BASE + 32'h8; wdata = '0;
    step();
    we = 0; addr = BASE + 32'h4;
    #1;
    checks++;
    if (rdata[23:16] !== 8'd7 || rx_ready !== 1'b1) begin
      failures++;
      $display("FAIL rx_pop_full got count=%0d ready=%b exp 7/1", rdata[23:16], rx_ready);
    end
    step();
    rx_valid = 0;
    #1;
    checks++;
    if (rdata[23:16] !== 8'd8 || rdata !== m_rdata(addr)) begin
      failures++; $display("FAIL rx_refill got=%h exp=%h", rdata, m_rdata(addr));
    end
    addr = BASE + 32'h8;
    #1;
    checks++;
    if (rdata !== m_rdata(addr)) begin
      failures++; $display("FAIL rx_head got=%h exp=%h", rdata, m_rdata(addr));
    end
    we = 1; addr = BASE + 32'hC; wdata = 32'h2;
    step();
    we = 0;
  endtask

  task automatic test_flush_reset();
    for (int i = 0; i < 2; i++) begin
      we = 1; addr = BASE; wdata = $urandom;
      step();
    end
    we = 1; addr = BASE + 32'hC; wdata = 32'h1; tx_ready = 1;
    step();
    we = 0; tx_ready = 0; addr = BASE + 32'h4;
    #1;
    checks++;
    if (tx_valid !== 1'b0 || rdata[15:8] !== 8'd0) begin
      failures++; $display("FAIL flush_pop got valid=%b count=%0d exp 0/0", tx_valid, rdata[15:8]);
    end
    we = 1; addr = BASE + 32'hC; wdata = 32'h2; rx_valid = 1; rx_data = 32'h77;
    step();
    we = 0; rx_valid = 0; addr = BASE + 32'h4;
    #1;
    checks++;
    if (rdata[3] !== 1'b1 || rdata[23:16] !== 8'd0) begin
      failures++; $display("FAIL flush_push got status=%h exp rx_empty", rdata);
    end
    for (int i = 0; i < 3; i++) begin
      we = 1; addr = BASE; wdata = $urandom; rx_valid = 1; rx_data = $urandom;
      step();
    end
    rst = 1; tx_ready = 1;
    #1;
    checks++;
    if (tx_valid !== 1'b0 || rx_ready !== 1'b0) begin
      failures++; $display("FAIL reset_mid got valid=%b ready=%b exp 0/0", tx_valid, rx_ready);
    end
    step();
    rst = 0; idle(); addr = BASE + 32'h4;
    #1;
    checks++;
    if (tx_valid !== 1'b0 || rdata !== 32'h0000_000A) begin
      failures++; $display("FAIL reset_mid_after got valid=%b status=%h exp 0/0000000a", tx_valid, rdata);
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [31:0] w;
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      a = BASE | ($urandom & 32'hF);
      if ($urandom_range(0, 7) == 0) a = 32'h0000_2000 | ($urandom & 32'hF);
      w = $urandom;
      if (a[3:2] == 2'd3 && $urandom_range(0, 7) != 0) w[1:0] = 2'b00;
      addr = a; wdata = w;
      we = $urandom_range(0, 1);
      tx_ready = ($urandom_range(0, 2) == 0);
      rx_valid = $urandom_range(0, 1);
      rx_data  = $urandom;
      #1;
      checks++;
      if (sel !== exp_sel(addr) || rdata !== m_rdata(addr)) begin
        failures++;
        $display("FAIL rand_read[%0d] addr=%h got sel=%b rdata=%h exp %b/%h",
                 n, addr, sel, rdata, exp_sel(addr), m_rdata(addr));
      end
      checks++;
      if (tx_valid !== exp_tx_valid() || tx_data !== exp_tx_data()) begin
        failures++;
        $display("FAIL rand_tx[%0d] got %b/%h exp %b/%h", n, tx_valid, tx_data,
                 exp_tx_valid(), exp_tx_data());
      end
      checks++;
      if (rx_ready !== exp_rx_ready() || irq !== exp_irq()) begin
        failures++;
        $display("FAIL rand_ctl[%0d] got ready=%b irq=%b exp %b/%b", n, rx_ready, irq,
                 exp_rx_ready(), exp_irq());
      end
      step();
    end
    rst = 0; idle();
  endtask

  initial begin
    test_reset();
    test_tx_order();
    test_tx_overflow();
    test_rx();
    test_rx_full();
    test_flush_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
